// File: rtl/pipe_stall_sched.sv
// pipe_stall_sched: EX/ID stall scheduler and mul/div sequencer for the
// 5-stage core. Drives the shared stall bus (bit0 PC .. bit5 WB), issues
// start/cancel to the HI/LO mul/div unit and counts stalled cycles.
module pipe_stall_sched #(
  parameter int MUL_LAT = 4,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               ex_md_req,
  input  logic               ex_md_is_div,
  input  logic               div_ready,
  input  logic               flush,
  output logic               md_start,
  output logic               md_cancel,
  output logic               md_done,
  output logic [STALL_W-1:0] stall,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int LW = 4;
  localparam logic [STALL_W-1:0] EX_STALL = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] ID_STALL = STALL_W'(6'b000111);

  typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             ex_stall;

  // State, latency counter and stall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state: flush aborts any operation; DONE always returns to IDLE so a
  // request still held in EX during DONE does not restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ex_md_req && !flush) begin
          if (ex_md_is_div) begin
            state_d = S_DIV_RUN;
          end else begin
            state_d = S_MUL_RUN;
            cnt_d   = LW'(MUL_LAT - 1);
          end
        end
      end
      S_MUL_RUN: begin
        if (flush)            state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_DONE;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      S_DIV_RUN: begin
        if (flush)          state_d = S_IDLE;
        else if (div_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: all forced low while reset is held so the bus is quiet
  // immediately on async reset, regardless of what EX/ID are requesting.
  always_comb begin
    ex_stall  = !flush && ((state_q == S_IDLE && ex_md_req) ||
                           state_q == S_MUL_RUN || state_q == S_DIV_RUN);
    md_start  = !rst && state_q == S_IDLE && ex_md_req && !flush;
    md_cancel = !rst && state_q == S_DIV_RUN && flush;
    md_done   = !rst && state_q == S_DONE && !flush;
    stall     = '0;
    if (!rst && !flush) begin
      stall = (ex_stall ? EX_STALL : '0) | (stallreq_id ? ID_STALL : '0);
    end
  end

  // Saturating count of cycles with the PC stalled
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall[0] && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_sched.sv
// tb_pipe_stall_sched: directed vectors for the stall scheduler (MUL_LAT=4).
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_pipe_stall_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, ex_md_req, ex_md_is_div, div_ready, flush;
  logic        md_start, md_cancel, md_done;
  logic [5:0]  stall;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stall_sched #(.MUL_LAT(4), .STALL_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_md_req(ex_md_req),
    .ex_md_is_div(ex_md_is_div), .div_ready(div_ready), .flush(flush),
    .md_start(md_start), .md_cancel(md_cancel), .md_done(md_done),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next active edge, ready to drive
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 0; ex_md_req = 0; ex_md_is_div = 0;
    div_ready = 0; flush = 0;

    // reset state
    smp();
    chk("rst_stall", 32'(stall), 32'h00);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_start", 32'(md_start), 0);
    chk("rst_done", 32'(md_done), 0);
    rst = 1'b0;

    // ID load-use stall for two cycles
    for (int i = 0; i < 2; i++) begin
      nxt(); stallreq_id = 1;
      smp(); chk("id_stall", 32'(stall), 32'h07);
    end
    nxt(); stallreq_id = 0;
    smp(); chk("id_cnt", stall_cnt, 2);
    chk("id_idle_stall", 32'(stall), 32'h00);

    // single multiply: stall cycles 0-4, done cycle 5
    nxt(); ex_md_req = 1; ex_md_is_div = 0;
    smp(); chk("mul_start", 32'(md_start), 1);
    chk("mul_stall0", 32'(stall), 32'h0F);
    for (int c = 1; c <= 4; c++) begin
      nxt(); smp();
      chk("mul_stall", 32'(stall), 32'h0F);
      chk("mul_nostart", 32'(md_start), 0);
      chk("mul_nodone", 32'(md_done), 0);
    end
    nxt(); smp();
    chk("mul_done", 32'(md_done), 1);
    chk("mul_done_stall", 32'(stall), 32'h00);
    chk("mul_done_nostart", 32'(md_start), 0);
    chk("mul_cnt", stall_cnt, 7);
    nxt(); ex_md_req = 0;
    smp(); chk("mul_after_done", 32'(md_done), 0);

    // divide with div_ready 10 cycles after start
    nxt(); ex_md_req = 1; ex_md_is_div = 1;
    smp(); chk("div_start", 32'(md_start), 1);
    chk("div_stall0", 32'(stall), 32'h0F);
    for (int c = 1; c <= 10; c++) begin
      nxt(); div_ready = (c == 10);
      smp();
      chk("div_stall", 32'(stall), 32'h0F);
      chk("div_nostart", 32'(md_start), 0);
      chk("div_nodone", 32'(md_done), 0);
    end
    nxt(); div_ready = 0;
    smp();
    chk("div_done", 32'(md_done), 1);
    chk("div_done_stall", 32'(stall), 32'h00);
    chk("div_done_nostart", 32'(md_start), 0);
    chk("div_cnt", stall_cnt, 18);
    nxt(); ex_md_req = 0; ex_md_is_div = 0;
    smp(); chk("div_idle", 32'(md_done), 0);

    // div_ready in IDLE is ignored
    nxt(); div_ready = 1;
    smp();
    nxt(); div_ready = 0;
    smp(); chk("idle_rdy_nodone", 32'(md_done), 0);
    chk("idle_rdy_stall", 32'(stall), 32'h00);

    // divide aborted by flush coinciding with div_ready
    nxt(); ex_md_req = 1; ex_md_is_div = 1;
    smp(); chk("dfl_start", 32'(md_start), 1);
    nxt(); smp(); nxt(); smp();
    chk("dfl_run_stall", 32'(stall), 32'h0F);
    nxt(); flush = 1; div_ready = 1;
    smp();
    chk("dfl_cancel", 32'(md_cancel), 1);
    chk("dfl_stall", 32'(stall), 32'h00);
    chk("dfl_nodone", 32'(md_done), 0);
    chk("dfl_nostart", 32'(md_start), 0);
    nxt(); flush = 0; div_ready = 0; ex_md_req = 0; ex_md_is_div = 0;
    smp();
    chk("dfl_after_done", 32'(md_done), 0);
    chk("dfl_after_cancel", 32'(md_cancel), 0);
    chk("dfl_cnt", stall_cnt, 21);

    // flush during MUL_RUN: back to IDLE, no cancel pulse
    nxt(); ex_md_req = 1;
    smp(); chk("mfl_start", 32'(md_start), 1);
    nxt(); flush = 1;
    smp();
    chk("mfl_cancel", 32'(md_cancel), 0);
    chk("mfl_stall", 32'(stall), 32'h00);
    nxt(); flush = 0; ex_md_req = 0;
    smp(); chk("mfl_after_done", 32'(md_done), 0);
    chk("mfl_cnt", stall_cnt, 22);

    // flush in IDLE suppresses start
    nxt(); ex_md_req = 1; flush = 1;
    smp();
    chk("ifl_nostart", 32'(md_start), 0);
    chk("ifl_stall", 32'(stall), 32'h00);
    nxt(); ex_md_req = 0; flush = 0;
    smp(); chk("ifl_idle", 32'(stall), 32'h00);

    // back-to-back multiplies, ID stall during second DONE
    nxt(); ex_md_req = 1;
    smp(); chk("b2b_start1", 32'(md_start), 1);
    for (int c = 1; c <= 4; c++) begin nxt(); smp(); end
    nxt(); smp(); chk("b2b_done1", 32'(md_done), 1);
    nxt(); smp();
    chk("b2b_start2", 32'(md_start), 1);
    chk("b2b_stall2", 32'(stall), 32'h0F);
    for (int c = 1; c <= 4; c++) begin
      nxt(); smp(); chk("b2b_run2", 32'(stall), 32'h0F);
    end
    nxt(); stallreq_id = 1;
    smp();
    chk("b2b_done2", 32'(md_done), 1);
    chk("b2b_done2_stall", 32'(stall), 32'h07);
    chk("b2b_cnt", stall_cnt, 32);
    nxt(); stallreq_id = 0; ex_md_req = 0;
    smp(); chk("b2b_cnt_after", stall_cnt, 33);

    // async reset in the middle of DIV_RUN
    nxt(); ex_md_req = 1; ex_md_is_div = 1;
    smp(); nxt(); smp(); nxt(); smp();
    chk("ar_pre_stall", 32'(stall), 32'h0F);
    #1 rst = 1;
    #1;
    chk("ar_stall", 32'(stall), 32'h00);
    chk("ar_cancel", 32'(md_cancel), 0);
    chk("ar_start", 32'(md_start), 0);
    chk("ar_cnt", stall_cnt, 0);
    smp(); ex_md_req = 0; ex_md_is_div = 0; rst = 0;
    nxt(); smp();
    chk("ar_idle_done", 32'(md_done), 0);
    chk("ar_idle_stall", 32'(stall), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
